// File: rtl/boe_batch_sorter.sv
// Batch statistics engine: SUM, MIN, optional MAX, then descending sort.
// Optional MAX output enabled by defining BOE_MAX_OUT_EN.
module boe_batch_sorter #(
   parameter int DATA_W = 8,
   parameter int MAX_N  = 6,
   parameter int CNT_W  = $clog2(MAX_N+1),
   parameter int SUM_W  = DATA_W+$clog2(MAX_N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [CNT_W-1:0]  data_num,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              out_valid,
   output logic [1:0]        out_tag,
   output logic [SUM_W-1:0]  result
);

   typedef enum logic [2:0] {
      S_RECV,
      S_SUM,
      S_MIN,
      S_MAX,
      S_SORT
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]  n_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  sidx_q;
   logic [SUM_W-1:0]  sum_q;
   logic [DATA_W-1:0] mn_q;
`ifdef BOE_MAX_OUT_EN
   logic [DATA_W-1:0] mx_q;
`endif
   logic [DATA_W-1:0] arr_q [MAX_N];
   logic [DATA_W-1:0] ins   [MAX_N];
   logic [SUM_W-1:0]  last_q;

   logic             first;
   logic             accept;
   logic             last_smp;
   logic             sort_end;
   logic [CNT_W-1:0] n_eff;
   logic [MAX_N-1:0] ge;

   // Batch length is taken from the first sample only, clamped to MAX_N
   always_comb begin
      first = (cnt_q == '0);
      n_eff = n_q;
      if (first) begin
         if (data_num > CNT_W'(MAX_N))
            n_eff = CNT_W'(MAX_N);
         else
            n_eff = data_num;
      end
      accept = (state == S_RECV) && in_valid
               && !(first && (data_num == '0));
      last_smp = accept && ((cnt_q + CNT_W'(1)) == n_eff);
      sort_end = (state == S_SORT)
                 && (sidx_q == (n_q - CNT_W'(1)));
   end

   // Array stays descending (empty slots are 0), so ge is a thermometer code
   always_comb begin
      for (int i = 0; i < MAX_N; i++)
         ge[i] = (data_in >= arr_q[i]);
      ins[0] = ge[0] ? data_in : arr_q[0];
      for (int i = 1; i < MAX_N; i++) begin
         if (!ge[i])
            ins[i] = arr_q[i];
         else if (!ge[i-1])
            ins[i] = data_in;
         else
            ins[i] = arr_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_RECV;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_RECV: if (last_smp) state_nxt = S_SUM;
         S_SUM:  state_nxt = S_MIN;
`ifdef BOE_MAX_OUT_EN
         S_MIN:  state_nxt = S_MAX;
`else
         S_MIN:  state_nxt = S_SORT;
`endif
         S_MAX:  state_nxt = S_SORT;
         S_SORT: if (sort_end) state_nxt = S_RECV;
         default: state_nxt = S_RECV;
      endcase
   end

   always_comb begin
      busy      = (state != S_RECV);
      out_valid = busy;
      out_tag   = 2'd0;
      result    = last_q;
      unique case (state)
         S_SUM: begin
            out_tag = 2'd0;
            result  = sum_q;
         end
         S_MIN: begin
            out_tag = 2'd1;
            result  = SUM_W'(mn_q);
         end
`ifdef BOE_MAX_OUT_EN
         S_MAX: begin
            out_tag = 2'd2;
            result  = SUM_W'(mx_q);
         end
`endif
         S_SORT: begin
            out_tag = 2'd3;
            result  = SUM_W'(arr_q[sidx_q]);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q    <= '0;
         cnt_q  <= '0;
         sidx_q <= '0;
         sum_q  <= '0;
         mn_q   <= '1;
`ifdef BOE_MAX_OUT_EN
         mx_q   <= '0;
`endif
         last_q <= '0;
         for (int i = 0; i < MAX_N; i++)
            arr_q[i] <= '0;
      end else begin
         if (state != S_RECV)
            last_q <= result;
         if (accept) begin
            sum_q <= sum_q + SUM_W'(data_in);
            if (data_in < mn_q)
               mn_q <= data_in;
`ifdef BOE_MAX_OUT_EN
            if (data_in > mx_q)
               mx_q <= data_in;
`endif
            arr_q <= ins;
            cnt_q <= cnt_q + CNT_W'(1);
            if (first)
               n_q <= n_eff;
         end
         if (state == S_SORT) begin
            if (sort_end) begin
               cnt_q  <= '0;
               sidx_q <= '0;
               sum_q  <= '0;
               mn_q   <= '1;
`ifdef BOE_MAX_OUT_EN
               mx_q   <= '0;
`endif
               for (int i = 0; i < MAX_N; i++)
                  arr_q[i] <= '0;
            end else begin
               sidx_q <= sidx_q + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_boe_batch_sorter.sv
// Directed bench for boe_batch_sorter with hand-computed result bursts.
// Honours BOE_MAX_OUT_EN so MAX entries appear only when built in.
module tb_boe_batch_sorter;

   localparam int DATA_W = 8;
   localparam int MAX_N  = 6;
   localparam int CNT_W  = 3;
   localparam int SUM_W  = 11;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic [CNT_W-1:0]  data_num;
   logic [DATA_W-1:0] data_in;
   logic              busy;
   logic              out_valid;
   logic [1:0]        out_tag;
   logic [SUM_W-1:0]  result;

   int checks;
   int errors;
   int exp_t [$];
   int exp_v [$];

   boe_batch_sorter #(
      .DATA_W(DATA_W),
      .MAX_N (MAX_N),
      .CNT_W (CNT_W),
      .SUM_W (SUM_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .data_num (data_num),
      .data_in  (data_in),
      .busy     (busy),
      .out_valid(out_valid),
      .out_tag  (out_tag),
      .result   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, need finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, need %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int dn, input int x);
      in_valid = 1'b1;
      data_num = CNT_W'(dn);
      data_in  = DATA_W'(x);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic want(input int t, input int v);
      exp_t.push_back(t);
      exp_v.push_back(v);
   endtask

   task automatic want_stats(input int s, input int mn, input int mx);
      want(0, s);
      want(1, mn);
`ifdef BOE_MAX_OUT_EN
      want(2, mx);
`else
      if (mx < 0) want(2, mx);
`endif
   endtask

   // Burst starts at the current sample point (one cycle after last sample)
   task automatic burst(input string name);
      for (int k = 0; k < exp_v.size(); k++) begin
         chk($sformatf("%s valid[%0d]", name, k), out_valid, 1);
         chk($sformatf("%s busy[%0d]", name, k), busy, 1);
         chk($sformatf("%s tag[%0d]", name, k), out_tag, exp_t[k]);
         chk($sformatf("%s res[%0d]", name, k), result, exp_v[k]);
         tick();
      end
      chk({name, " end valid"}, out_valid, 0);
      chk({name, " end busy"}, busy, 0);
      exp_t.delete();
      exp_v.delete();
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      data_num = '0;
      data_in  = '0;
      #3;
      chk("rst busy", busy, 0);
      chk("rst valid", out_valid, 0);
      chk("rst result", result, 0);
      chk("rst tag", out_tag, 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("idle busy", busy, 0);
      chk("idle valid", out_valid, 0);
      chk("idle result", result, 0);

      // N=6 with gaps and a duplicate
      send(6, 5);
      send(0, 9);
      repeat (3) tick();
      chk("gap busy", busy, 0);
      send(0, 1);
      send(0, 9);
      send(0, 3);
      send(0, 7);
      want_stats(34, 1, 9);
      want(3, 9); want(3, 9); want(3, 7);
      want(3, 5); want(3, 3); want(3, 1);
      burst("n6");
      chk("n6 hold", result, 1);
      chk("n6 hold tag", out_tag, 0);

      // N=1
      send(1, 200);
      want_stats(200, 200, 200);
      want(3, 200);
      burst("n1");

      // Full-scale samples: no wrap in SUM
      for (int i = 0; i < 6; i++) send(6, 255);
      want_stats(1530, 255, 255);
      for (int i = 0; i < 6; i++) want(3, 255);
      burst("max");

      // data_num=0 is dropped, data_num=7 clamps to 6
      send(0, 50);
      tick();
      chk("n0 busy", busy, 0);
      send(7, 10);
      send(0, 20);
      send(0, 30);
      send(0, 40);
      send(0, 50);
      chk("clamp busy5", busy, 0);
      send(0, 60);
      want_stats(210, 10, 60);
      want(3, 60); want(3, 50); want(3, 40);
      want(3, 30); want(3, 20); want(3, 10);
      burst("clamp");

      // in_valid held high through the burst is ignored
      send(3, 2);
      send(0, 2);
      send(0, 6);
      in_valid = 1'b1;
      data_num = CNT_W'(1);
      data_in  = 8'd99;
      want_stats(10, 2, 6);
      want(3, 6); want(3, 2); want(3, 2);
      burst("held");
      in_valid = 1'b0;

      // Reset mid-SORT, then a fresh batch
      send(4, 1);
      send(0, 2);
      send(0, 3);
      send(0, 4);
      chk("pre-rst sum", result, 10);
      tick();
`ifdef BOE_MAX_OUT_EN
      tick();
`endif
      tick();
      chk("mid sort tag", out_tag, 3);
      chk("mid sort res", result, 4);
      tick();
      rst = 1'b1;
      #1;
      chk("arst busy", busy, 0);
      chk("arst valid", out_valid, 0);
      chk("arst result", result, 0);
      chk("arst tag", out_tag, 0);
      tick();
      rst = 1'b0;
      tick();
      send(2, 4);
      send(0, 8);
      want_stats(12, 4, 8);
      want(3, 8); want(3, 4);
      burst("post");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
